serial_adder_ctrl: RTL and testbench

Bit-serial WIDTH-bit adder controller that time-shares one half_adder_behavioural instance (ports a, b, sum, carry) as a full adder.
- Two half-adder passes per bit: operand pass, then carry pass.
- Sequences operand bits LSB-first and latches intermediate carries.
- Accumulates result bits in an internal shift register.
- Sits between a simple start/done requester and the shared half-adder datapath.

---
 rtl/serial_adder_ctrl.sv | 158 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_ctrl
// Brief    : Bit-serial WIDTH-bit adder that reuses one half adder as a full
//            adder, spending two passes per bit (operand pass, carry pass).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int                 c_idx_w = $clog2(WIDTH);
  localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P1   = 2'd1,
    S_P2   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [c_idx_w-1:0] r_idx;
  logic               r_cin;
  logic               r_s1;
  logic               r_c1;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_ha_a;
  logic               w_ha_b;
  logic               w_ha_sum;
  logic               w_ha_carry;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic               w_cin_nxt;

  half_adder_behavioural u_ha (
    .a     (w_ha_a),
    .b     (w_ha_b),
    .sum   (w_ha_sum),
    .carry (w_ha_carry)
  );

  // Result bits enter at the MSB, so after WIDTH carry passes bit 0 is the LSB.
  assign w_shift_nxt = {w_ha_sum, r_shift[WIDTH-1:1]};
  assign w_cin_nxt   = r_c1 | w_ha_carry;
  assign sum         = r_sum;
  assign carry_out   = r_cout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_ha_a      = 1'b0;
    w_ha_b      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_P1;
      end
      S_P1: begin
        busy        = 1'b1;
        w_ha_a      = r_a[r_idx];
        w_ha_b      = r_b[r_idx];
        w_state_nxt = S_P2;
      end
      S_P2: begin
        busy        = 1'b1;
        w_ha_a      = r_s1;
        w_ha_b      = r_cin;
        w_state_nxt = (r_idx == c_last) ? S_DONE : S_P1;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_cin   <= 1'b0;
      r_s1    <= 1'b0;
      r_c1    <= 1'b0;
      r_shift <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_cin <= 1'b0;
            r_idx <= '0;
          end
        end
        S_P1: begin
          r_s1 <= w_ha_sum;
          r_c1 <= w_ha_carry;
        end
        S_P2: begin
          r_shift <= w_shift_nxt;
          r_cin   <= w_cin_nxt;
          if (r_idx == c_last) begin
            r_sum  <= w_shift_nxt;
            r_cout <= w_cin_nxt;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// Shared single-bit datapath element.
module half_adder_behavioural (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder_ctrl
// Brief    : Self-checking bench for serial_adder_ctrl against an a+b model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int c_w = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [c_w-1:0] a;
  logic [c_w-1:0] b;
  logic           busy;
  logic           done;
  logic [c_w-1:0] sum;
  logic           carry_out;

  int total = 0;
  int bad   = 0;

  // Model: last {carry_out,sum} the DUT should be presenting.
  logic [c_w:0] r_res_q;

  serial_adder_ctrl #(.WIDTH(c_w)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [c_w-1:0] x, input logic [c_w-1:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) until done is high; counts elapsed cycles and busy cycles.
  task automatic wait_done(input bit scramble, output int n, output int nb, output bit ok);
    n  = 0;
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nb++;
      if (scramble) begin
        @(negedge clk);
        a     = c_w'($urandom);
        b     = c_w'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
  endtask

  task automatic do_add(input logic [c_w-1:0] x, input logic [c_w-1:0] y,
                        input bit scramble, input string tag);
    int           n;
    int           nb;
    bit           ok;
    logic [c_w:0] exp;
    exp = {1'b0, x} + {1'b0, y};
    launch(x, y);
    check({tag, "_held"}, {carry_out, sum}, r_res_q);
    wait_done(scramble, n, nb, ok);
    check({tag, "_done_seen"}, ok, 1);
    check({tag, "_latency"}, n + 1, 2 * c_w + 1);
    check({tag, "_busy_cycles"}, nb, 2 * c_w);
    check({tag, "_busy_in_done"}, busy, 0);
    check({tag, "_result"}, {carry_out, sum}, exp);
    r_res_q = exp;
    @(negedge clk);
    start = 1'b0;
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int           n;
    int           nb;
    bit           ok;
    int           changes;
    int           pulses;
    int           last_t;
    logic [c_w:0] prev;

    reset   = 1'b1;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    r_res_q = '0;
    repeat (2) tick();
    check("rst_outputs", {busy, done, carry_out, sum}, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_idle", {busy, done}, 0);

    do_add(8'h00, 8'h00, 1'b0, "t1_zero");
    do_add(8'h0F, 8'h01, 1'b0, "t2_0f_01");
    do_add(8'hA5, 8'h5A, 1'b0, "t2_a5_5a");
    do_add(8'hFF, 8'h01, 1'b0, "t3_ff_01");
    do_add(8'hFF, 8'hFF, 1'b0, "t3_ff_ff");
    do_add(8'h80, 8'h80, 1'b0, "t3_80_80");

    // Starts during busy and during DONE are ignored; next IDLE edge accepts.
    launch(8'h12, 8'h34);
    repeat (3) tick();
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    tick();
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, n, nb, ok);
    check("t4_done_seen", ok, 1);
    check("t4_latency", n + 5, 2 * c_w + 1);
    check("t4_result", {carry_out, sum}, 9'h046);
    @(negedge clk);
    start = 1'b1;
    tick();
    check("t4_done_start_ignored", {busy, done}, 0);
    tick();
    check("t4_next_accept", busy, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, n, nb, ok);
    check("t4b_done_seen", ok, 1);
    check("t4b_result", {carry_out, sum}, 9'h1FE);
    r_res_q = 9'h1FE;
    tick();

    // Reset mid-operation.
    launch(8'hFF, 8'h01);
    repeat (5) tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_async_clear", {busy, done, carry_out, sum}, 0);
    @(negedge clk);
    reset   = 1'b0;
    r_res_q = '0;
    pulses  = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) pulses++;
    end
    check("t5_no_done", pulses, 0);
    check("t5_cleared", {busy, carry_out, sum}, 0);
    do_add(8'h03, 8'h04, 1'b0, "t5_after");

    // Start held high: back-to-back operations.
    @(negedge clk);
    a       = 8'h01;
    b       = 8'h01;
    start   = 1'b1;
    changes = 0;
    pulses  = 0;
    last_t  = -1;
    prev    = {carry_out, sum};
    for (int t = 0; t < 80; t++) begin
      tick();
      if (done) begin
        pulses++;
        check("t6_result", {carry_out, sum}, 9'h002);
        if (last_t >= 0) check("t6_spacing", t - last_t, 2 * c_w + 2);
        last_t = t;
      end else if ({carry_out, sum} !== prev) begin
        changes++;
      end
      prev = {carry_out, sum};
    end
    check("t6_pulses", pulses, 4);
    check("t6_stable", changes, 0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, n, nb, ok);
    tick();
    tick();
    r_res_q = 9'h002;

    // Randomized operands; half the runs churn inputs while busy.
    for (int k = 0; k < 24; k++) begin
      do_add(c_w'($urandom), c_w'($urandom), k[0], $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
